// File: rtl/aes0_ct_buffer_pkg.sv
// Shared aes0 definitions: datapath widths, head-word select encoding and the
// scrub FSM state type used by the ciphertext result buffer.
package aes0_ct_buffer_pkg;

  localparam int unsigned AES0_CT_W   = 128;
  localparam int unsigned AES0_WORD_W = 32;

  typedef enum logic [1:0] {
    WordSel0 = 2'd0,
    WordSel1 = 2'd1,
    WordSel2 = 2'd2,
    WordSel3 = 2'd3
  } word_sel_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StScrub = 1'b1
  } state_e;

  // Word 0 is the least significant 32 bits of the ciphertext.
  function automatic logic [AES0_WORD_W-1:0] get_word(input logic [AES0_CT_W-1:0] ct,
                                                      input logic [1:0]           sel);
    logic [AES0_WORD_W-1:0] w;
    unique case (sel)
      WordSel0: w = ct[31:0];
      WordSel1: w = ct[63:32];
      WordSel2: w = ct[95:64];
      WordSel3: w = ct[127:96];
      default:  w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes0_ct_buffer_if.sv
// Engine/software-facing signal bundle of the ciphertext result buffer.
interface aes0_ct_buffer_if
  import aes0_ct_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [AES0_CT_W-1:0]   ct;
  logic                   ct_valid;
  logic                   pop;
  logic                   flush;
  logic [1:0]             word_sel;
  logic                   lock;
  logic [AES0_WORD_W-1:0] rdata;
  logic                   empty;
  logic                   full;
  logic [CntW-1:0]        count;
  logic                   overflow;
  logic                   busy;

  modport master (
    output ct, ct_valid, pop, flush, word_sel, lock,
    input  rdata, empty, full, count, overflow, busy
  );

  modport slave (
    input  ct, ct_valid, pop, flush, word_sel, lock,
    output rdata, empty, full, count, overflow, busy
  );

endinterface

// File: rtl/aes0_ct_mem.sv
// DEPTH x 128-bit register array: one synchronous write port, one asynchronous
// read port, cleared to zero by reset.
module aes0_ct_mem
  import aes0_ct_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [AES0_CT_W-1:0]       wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [AES0_CT_W-1:0]       rdata_o
);

  logic [AES0_CT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aes0_ct_buffer.sv
// Ciphertext result FIFO behind the AES-192 engine: one capture per valid pulse,
// word-wise head readout, and a fixed-length zero scrub on flush.
module aes0_ct_buffer
  import aes0_ct_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  aes0_ct_buffer_if.slave    bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  state_e               state_q;
  logic [AW-1:0]        wp_q, rp_q, si_q;
  logic [CntW-1:0]      cnt_q;
  logic                 ovf_q;
  logic                 vld_q;

  logic                 is_idle, empty, full, cap_ev, pop_ok, cap_ok, cap_drop;
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [AES0_CT_W-1:0] mem_wdata, head;

  assign is_idle = (state_q == StIdle);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(DEPTH));
  assign cap_ev  = bus.ct_valid & ~vld_q;

  // Flush takes priority over both capture and pop; a pop frees a slot for a
  // same-cycle capture when full.
  assign pop_ok   = is_idle & ~bus.flush & bus.pop & ~empty;
  assign cap_ok   = is_idle & ~bus.flush & cap_ev & (~full | pop_ok);
  assign cap_drop = cap_ev & (~is_idle | (~bus.flush & full & ~pop_ok));

  assign mem_we    = cap_ok | ~is_idle;
  assign mem_waddr = is_idle ? wp_q : si_q;
  assign mem_wdata = is_idle ? bus.ct : '0;

  aes0_ct_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (rp_q),
    .rdata_o (head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      wp_q    <= '0;
      rp_q    <= '0;
      si_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= bus.ct_valid;
      unique case (state_q)
        StIdle: begin
          if (bus.flush) begin
            state_q <= StScrub;
            wp_q    <= '0;
            rp_q    <= '0;
            si_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end else begin
            if (cap_ok) wp_q <= wp_q + AW'(1);
            if (pop_ok) rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + CntW'(cap_ok) - CntW'(pop_ok);
            if (cap_drop) ovf_q <= 1'b1;
          end
        end
        StScrub: begin
          si_q <= si_q + AW'(1);
          if (cap_drop) ovf_q <= 1'b1;
          if (si_q == AW'(DEPTH - 1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (!(bus.lock || empty || !is_idle)) begin
      bus.rdata = get_word(head, bus.word_sel);
    end
  end

  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = cnt_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = ~is_idle;

endmodule

// File: tb/tb_aes0_ct_buffer.sv
// Scoreboard bench for aes0_ct_buffer: stimulus queues expected observations,
// a negedge monitor pops and compares them against the DUT.
module tb_aes0_ct_buffer;
  import aes0_ct_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;

  localparam int KRd    = 0;
  localparam int KCnt   = 1;
  localparam int KEmpty = 2;
  localparam int KFull  = 3;
  localparam int KOvf   = 4;
  localparam int KBusy  = 5;
  localparam int KMem   = 6;

  typedef struct {
    string          name;
    int             kind;
    int             idx;
    logic [127:0]   exp;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  sb_item_t sb_q[$];

  always #5 clk = ~clk;

  aes0_ct_buffer_if #(.DEPTH(DEPTH)) bus ();

  aes0_ct_buffer #(
    .DEPTH(DEPTH)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  sb_item_t     it;
  logic [127:0] act;
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.kind)
        KRd:     act = 128'(bus.rdata);
        KCnt:    act = 128'(bus.count);
        KEmpty:  act = 128'(bus.empty);
        KFull:   act = 128'(bus.full);
        KOvf:    act = 128'(bus.overflow);
        KBusy:   act = 128'(bus.busy);
        KMem:    act = u_dut.u_mem.mem_q[it.idx];
        default: act = 'x;
      endcase
      n_tests++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h required %0h", it.name, act, it.exp);
      end
    end
  end

  task automatic exp_push(input string name, input int kind, input logic [127:0] exp,
                          input int idx = 0);
    sb_item_t s;
    s.name = name;
    s.kind = kind;
    s.idx  = idx;
    s.exp  = exp;
    sb_q.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [127:0] v);
    bus.ct       = v;
    bus.ct_valid = 1'b1;
    tick();
    bus.ct_valid = 1'b0;
    tick();
  endtask

  task automatic pop1();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [1:0] sel, input logic [31:0] exp);
    bus.word_sel = sel;
    exp_push(name, KRd, 128'(exp));
    tick();
  endtask

  task automatic chk_mem_zero(input string name);
    for (int i = 0; i < DEPTH; i++) exp_push(name, KMem, '0, i);
  endtask

  task automatic chk_reset_vals(input string name);
    exp_push({name, "_empty"}, KEmpty, 128'd1);
    exp_push({name, "_full"},  KFull,  128'd0);
    exp_push({name, "_count"}, KCnt,   128'd0);
    exp_push({name, "_ovf"},   KOvf,   128'd0);
    exp_push({name, "_busy"},  KBusy,  128'd0);
    exp_push({name, "_rdata"}, KRd,    128'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.ct       = '0;
    bus.ct_valid = 1'b0;
    bus.pop      = 1'b0;
    bus.flush    = 1'b0;
    bus.word_sel = 2'd0;
    bus.lock     = 1'b0;

    // Reset state
    chk_reset_vals("rst");
    chk_mem_zero("rst_mem");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Long valid level yields a single capture
    bus.ct       = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    bus.ct_valid = 1'b1;
    repeat (5) tick();
    bus.ct_valid = 1'b0;
    tick();
    exp_push("cap_count", KCnt, 128'd1);
    chk_rd("cap_w0", 2'd0, 32'hCCDDEEFF);
    chk_rd("cap_w1", 2'd1, 32'h8899AABB);
    chk_rd("cap_w2", 2'd2, 32'h44556677);
    chk_rd("cap_w3", 2'd3, 32'h00112233);
    bus.word_sel = 2'd0;
    pop1();
    exp_push("cap_pop_empty", KEmpty, 128'd1);
    tick();

    // Fill and overflow
    for (int i = 1; i <= 5; i++) pulse(128'(i));
    exp_push("fill_full",  KFull, 128'd1);
    exp_push("fill_ovf",   KOvf,  128'd1);
    exp_push("fill_count", KCnt,  128'd4);
    exp_push("fill_head",  KRd,   128'd1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      exp_push($sformatf("fill_rd%0d", i), KRd, 128'(i));
      pop1();
    end
    exp_push("drain_empty", KEmpty, 128'd1);
    exp_push("drain_ovf",   KOvf,   128'd1);
    exp_push("drain_count", KCnt,   128'd0);
    tick();

    // Flush to clear overflow, then full with same-cycle capture and pop
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (DEPTH) tick();
    exp_push("flush_ovf_clr", KOvf, 128'd0);
    tick();
    for (int i = 5; i <= 8; i++) pulse(128'(i));
    bus.ct       = 128'd9;
    bus.ct_valid = 1'b1;
    bus.pop      = 1'b1;
    tick();
    bus.ct_valid = 1'b0;
    bus.pop      = 1'b0;
    exp_push("cp_count", KCnt, 128'd4);
    exp_push("cp_ovf",   KOvf, 128'd0);
    tick();
    for (int i = 6; i <= 9; i++) begin
      exp_push($sformatf("cp_rd%0d", i), KRd, 128'(i));
      pop1();
    end

    // Lock, pop on empty, capture+pop on empty
    pulse(128'hA);
    pulse(128'hB);
    bus.lock = 1'b1;
    exp_push("lock_rd", KRd, 128'd0);
    tick();
    bus.lock = 1'b0;
    exp_push("unlock_rd", KRd, 128'hA);
    tick();
    pop1();
    pop1();
    pop1();
    exp_push("popempty_count", KCnt, 128'd0);
    tick();
    bus.ct       = 128'hC;
    bus.ct_valid = 1'b1;
    bus.pop      = 1'b1;
    tick();
    bus.ct_valid = 1'b0;
    bus.pop      = 1'b0;
    exp_push("empty_cp_count", KCnt, 128'd1);
    exp_push("empty_cp_head",  KRd,  128'hC);
    tick();
    pop1();

    // Flush scrub with a capture attempt while busy
    pulse(128'h11);
    pulse(128'h22);
    pulse(128'h33);
    exp_push("scr_pre_count", KCnt, 128'd3);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    exp_push("scr_busy1",  KBusy, 128'd1);
    exp_push("scr_count0", KCnt,  128'd0);
    exp_push("scr_rd0",    KRd,   128'd0);
    bus.ct       = 128'h77;
    bus.ct_valid = 1'b1;
    tick();
    exp_push("scr_busy2", KBusy, 128'd1);
    exp_push("scr_ovf",   KOvf,  128'd1);
    tick();
    exp_push("scr_busy3", KBusy, 128'd1);
    tick();
    exp_push("scr_busy4", KBusy, 128'd1);
    tick();
    exp_push("scr_idle",  KBusy,  128'd0);
    exp_push("scr_cnt",   KCnt,   128'd0);
    exp_push("scr_empty", KEmpty, 128'd1);
    exp_push("scr_ovf_k", KOvf,   128'd1);
    chk_mem_zero("scr_mem");
    tick();
    bus.ct_valid = 1'b0;
    exp_push("scr_held_valid_cnt", KCnt, 128'd0);
    tick();

    // Reset in the second busy cycle
    pulse(128'hAB);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.ct       = 128'h99;
    bus.ct_valid = 1'b1;
    tick();
    exp_push("mid_busy2", KBusy, 128'd1);
    exp_push("mid_ovf",   KOvf,  128'd1);
    @(negedge clk);
    #1;
    rst_n        = 1'b0;
    bus.ct_valid = 1'b0;
    chk_reset_vals("midrst");
    chk_mem_zero("midrst_mem");
    tick();
    rst_n = 1'b1;
    exp_push("post_rst_busy", KBusy, 128'd0);
    tick();
    pulse(128'h5A);
    exp_push("post_rst_count", KCnt, 128'd1);
    chk_rd("post_rst_rd", 2'd0, 32'h5A);

    tick();
    tick();
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d items left required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
